// File: rtl/gdt_table_param.sv
// ---------------------------------------------------------------------------
// gdt_table_param
//   Per-guest descriptor table for the hypervisor monitor: GUESTS tables of
//   ENTRIES words (DATA_W bits each) behind one single-cycle access port.
//   Reads are registered (one cycle latency, o_valid strobe), out-of-range
//   accesses raise o_err, and a small sequencer zeroes one guest table on
//   request (guest teardown).
//
//   Optional feature: define GDT_LOCK_EN to add a per-guest write lock and
//   the lock_wr port.
//
// Ports
//   clock        sole clock, rising edge
//   reset        asynchronous, active-high
//   enable       access request
//   RD0_WR1      access type: 0 = read, 1 = write
//   guest_line   guest index
//   GDT_column   descriptor index within the guest table
//   i_data       write data (bit 0 is also the lock value for lock_wr)
//   o_data       registered read data, holds when no read completes
//   o_valid      one-cycle strobe: o_data was updated by a read
//   o_err        one-cycle strobe: out-of-range / locked access or clear
//   clear_req    request to zero guest clear_guest
//   clear_guest  guest to clear, sampled with clear_req
//   busy         clear sequence in progress (CLEAR or DONE)
//   clear_done   one-cycle strobe at the end of a clear
//   lock_wr      (GDT_LOCK_EN only) lock[guest_line] <= i_data[0]
// ---------------------------------------------------------------------------
module gdt_table_param #(
  parameter  int DATA_W  = 32,
  parameter  int GUESTS  = 8,
  parameter  int ENTRIES = 8,
  localparam int GW      = (GUESTS  > 1) ? $clog2(GUESTS)  : 1,
  localparam int EW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              RD0_WR1,
  input  logic [GW-1:0]     guest_line,
  input  logic [EW-1:0]     GDT_column,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_err,
  input  logic              clear_req,
  input  logic [GW-1:0]     clear_guest,
  output logic              busy,
  output logic              clear_done
`ifdef GDT_LOCK_EN
  ,
  input  logic              lock_wr
`endif
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

  // One extra bit so GUESTS/ENTRIES themselves are representable when they
  // are powers of two.
  localparam logic [GW:0]   GUESTS_L  = (GW+1)'(GUESTS);
  localparam logic [EW:0]   ENTRIES_L = (EW+1)'(ENTRIES);
  localparam logic [EW-1:0] LAST_CNT  = EW'(ENTRIES - 1);

  state_e            state_q, state_d;
  logic [EW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     guest_q, guest_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_q [GUESTS][ENTRIES];

  logic              idle;
  logic              access;
  logic              acc_in_range;
  logic              clr_in_range;
  logic              acc_locked;
  logic              clr_locked;
  logic              wr_en;

  assign idle         = (state_q == IDLE);
  assign acc_in_range = ({1'b0, guest_line} < GUESTS_L) &&
                        ({1'b0, GDT_column} < ENTRIES_L);
  assign clr_in_range = ({1'b0, clear_guest} < GUESTS_L);

`ifdef GDT_LOCK_EN
  logic [GUESTS-1:0] lock_q;

  // lock_wr wins over enable; that cycle performs no table access.
  assign access     = idle && enable && !lock_wr;
  assign acc_locked = acc_in_range && lock_q[guest_line];
  assign clr_locked = clr_in_range && lock_q[clear_guest];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_q <= '0;
    end else if (idle && lock_wr && ({1'b0, guest_line} < GUESTS_L)) begin
      lock_q[guest_line] <= i_data[0];
    end
  end
`else
  assign access     = idle && enable;
  assign acc_locked = 1'b0;
  assign clr_locked = 1'b0;
`endif

  assign wr_en = access && RD0_WR1 && acc_in_range && !acc_locked;

  // Next state and registered outputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    guest_d = guest_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (access) begin
      if (!RD0_WR1) begin
        valid_d = 1'b1;
        data_d  = acc_in_range ? mem_q[guest_line][GDT_column] : '0;
      end
      if (!acc_in_range || (RD0_WR1 && acc_locked)) err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          guest_d = clear_guest;
          cnt_d   = '0;
          // A bad or locked guest skips straight to DONE with nothing cleared.
          if (!clr_in_range || clr_locked) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = CLEAR;
          end
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      guest_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      guest_q <= guest_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Host writes only happen in IDLE and clear writes only in CLEAR, so the
  // two write sources never collide.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the table is built from flops and is reset explicitly, because
      // teardown semantics require every entry to read zero after reset.
      for (int g = 0; g < GUESTS; g++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          mem_q[g][e] <= '0;
        end
      end
    end else begin
      if (wr_en) mem_q[guest_line][GDT_column] <= i_data;
      if (state_q == CLEAR) mem_q[guest_q][cnt_q] <= '0;
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_err      = err_q;
  assign busy       = (state_q != IDLE);
  assign clear_done = (state_q == DONE);

endmodule

// File: tb/tb_gdt_table_param.sv
// ---------------------------------------------------------------------------
// tb_gdt_table_param
//   Directed bench for gdt_table_param with GUESTS=5, ENTRIES=8, DATA_W=32.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at
//   the same point, i.e. they show the result of the edge just taken.
//   Define GDT_LOCK_EN for both bench and RTL to exercise the lock feature.
// ---------------------------------------------------------------------------
module tb_gdt_table_param;

  localparam int DATA_W  = 32;
  localparam int GUESTS  = 5;
  localparam int ENTRIES = 8;
  localparam int GW      = 3;
  localparam int EW      = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              RD0_WR1;
  logic [GW-1:0]     guest_line;
  logic [EW-1:0]     GDT_column;
  logic [DATA_W-1:0] i_data;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_err;
  logic              clear_req;
  logic [GW-1:0]     clear_guest;
  logic              busy;
  logic              clear_done;
`ifdef GDT_LOCK_EN
  logic              lock_wr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  gdt_table_param #(
    .DATA_W (DATA_W),
    .GUESTS (GUESTS),
    .ENTRIES(ENTRIES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .RD0_WR1    (RD0_WR1),
    .guest_line (guest_line),
    .GDT_column (GDT_column),
    .i_data     (i_data),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_err      (o_err),
    .clear_req  (clear_req),
    .clear_guest(clear_guest),
    .busy       (busy),
    .clear_done (clear_done)
`ifdef GDT_LOCK_EN
    ,
    .lock_wr    (lock_wr)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [GW-1:0] g, input logic [EW-1:0] c, input logic [31:0] d);
    enable = 1'b1; RD0_WR1 = 1'b1; guest_line = g; GDT_column = c; i_data = d;
    tick();
    enable = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [GW-1:0] g, input logic [EW-1:0] c,
                          input logic [31:0] exp);
    enable = 1'b1; RD0_WR1 = 1'b0; guest_line = g; GDT_column = c;
    tick();
    enable = 1'b0;
    check(tag, o_data, exp);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy; i++) tick();
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int busy_n;
    int done_n;
    logic valid_seen;

    reset = 1'b1; enable = 1'b0; RD0_WR1 = 1'b0; guest_line = '0; GDT_column = '0;
    i_data = '0; clear_req = 1'b0; clear_guest = '0;
`ifdef GDT_LOCK_EN
    lock_wr = 1'b0;
`endif
    #2;
    check("rst o_data", o_data, 32'd0);
    check("rst o_valid", {31'd0, o_valid}, 32'd0);
    check("rst o_err", {31'd0, o_err}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst clear_done", {31'd0, clear_done}, 32'd0);
    #10 reset = 1'b0;
    tick();

    // Basic write then read.
    wr(0, 1, 32'hF0FF_FFFF);
    check("wr0 o_valid", {31'd0, o_valid}, 32'd0);
    check("wr0 o_err", {31'd0, o_err}, 32'd0);
    rd_check("rd g0c1", 0, 1, 32'hF0FF_FFFF);
    check("rd g0c1 valid", {31'd0, o_valid}, 32'd1);
    check("rd g0c1 err", {31'd0, o_err}, 32'd0);
    tick();
    check("hold valid", {31'd0, o_valid}, 32'd0);
    check("hold data", o_data, 32'hF0FF_FFFF);

    // Read the cycle right after a write to the same address.
    wr(3, 7, 32'h1234_5678);
    rd_check("raw g3c7", 3, 7, 32'h1234_5678);
    check("raw valid", {31'd0, o_valid}, 32'd1);

    // Out-of-range guest (6 >= GUESTS).
    rd_check("oor rd data", 6, 0, 32'd0);
    check("oor rd valid", {31'd0, o_valid}, 32'd1);
    check("oor rd err", {31'd0, o_err}, 32'd1);
    wr(6, 1, 32'hCAFE_CAFE);
    check("oor wr err", {31'd0, o_err}, 32'd1);
    check("oor wr valid", {31'd0, o_valid}, 32'd0);
    tick();
    check("oor err pulse", {31'd0, o_err}, 32'd0);
    rd_check("oor g1c1 intact", 1, 1, 32'd0);
    rd_check("oor g0c1 intact", 0, 1, 32'hF0FF_FFFF);

    // Fill guests 2 and 3, then clear guest 2 with a read pending while busy.
    for (int c = 0; c < ENTRIES; c++) wr(2, EW'(c), 32'hAAAA_5555);
    for (int c = 0; c < ENTRIES; c++) wr(3, EW'(c), 32'hAAAA_5555);
    clear_req = 1'b1; clear_guest = 2;
    tick();
    clear_req = 1'b0;
    enable = 1'b1; RD0_WR1 = 1'b0; guest_line = 3; GDT_column = 0;
    busy_n = 0; done_n = 0; valid_seen = 1'b0;
    for (int i = 0; i < 20 && busy; i++) begin
      busy_n++;
      if (clear_done) done_n++;
      if (o_valid) valid_seen = 1'b1;
      tick();
    end
    if (clear_done) done_n++;
    if (o_valid) valid_seen = 1'b1;
    enable = 1'b0;
    check("clr busy cycles", busy_n, ENTRIES + 1);
    check("clr done pulses", done_n, 32'd1);
    check("clr no valid busy", {31'd0, valid_seen}, 32'd0);
    check("clr idle again", {31'd0, busy}, 32'd0);
    for (int c = 0; c < ENTRIES; c++) rd_check($sformatf("clr g2c%0d", c), 2, EW'(c), 32'd0);
    for (int c = 0; c < ENTRIES; c++)
      rd_check($sformatf("keep g3c%0d", c), 3, EW'(c), 32'hAAAA_5555);

    // Write and clear to the same guest in one cycle: the clear wins.
    enable = 1'b1; RD0_WR1 = 1'b1; guest_line = 2; GDT_column = 0; i_data = 32'h11;
    clear_req = 1'b1; clear_guest = 2;
    tick();
    enable = 1'b0; clear_req = 1'b0;
    check("wr+clr busy", {31'd0, busy}, 32'd1);
    wait_idle("wr+clr idle");
    rd_check("wr+clr g2c0", 2, 0, 32'd0);

    // Read serviced in the same cycle a clear of another guest starts.
    enable = 1'b1; RD0_WR1 = 1'b0; guest_line = 3; GDT_column = 0;
    clear_req = 1'b1; clear_guest = 4;
    tick();
    enable = 1'b0; clear_req = 1'b0;
    check("rd+clr valid", {31'd0, o_valid}, 32'd1);
    check("rd+clr data", o_data, 32'hAAAA_5555);
    check("rd+clr busy", {31'd0, busy}, 32'd1);
    wait_idle("rd+clr idle");

    // Clear request for a nonexistent guest goes straight to DONE.
    clear_req = 1'b1; clear_guest = 6;
    tick();
    clear_req = 1'b0;
    check("oor clr busy", {31'd0, busy}, 32'd1);
    check("oor clr done", {31'd0, clear_done}, 32'd1);
    check("oor clr err", {31'd0, o_err}, 32'd1);
    tick();
    check("oor clr idle", {31'd0, busy}, 32'd0);

    // Reset asserted during the third CLEAR cycle.
    rd_check("pre-rst g3c7", 3, 7, 32'hAAAA_5555);
    clear_req = 1'b1; clear_guest = 3;
    tick();
    clear_req = 1'b0;
    tick();
    tick();
    check("mid-clr busy", {31'd0, busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst mid busy", {31'd0, busy}, 32'd0);
    check("rst mid o_data", o_data, 32'd0);
    check("rst mid o_valid", {31'd0, o_valid}, 32'd0);
    check("rst mid o_err", {31'd0, o_err}, 32'd0);
    check("rst mid clear_done", {31'd0, clear_done}, 32'd0);
    #2 reset = 1'b0;
    tick();
    check("post-rst no done", {31'd0, clear_done}, 32'd0);
    for (int g = 0; g < GUESTS; g++)
      for (int c = 0; c < ENTRIES; c++)
        rd_check($sformatf("zero g%0dc%0d", g, c), GW'(g), EW'(c), 32'd0);

`ifdef GDT_LOCK_EN
    wr(1, 2, 32'h0BAD_F00D);
    lock_wr = 1'b1; guest_line = 1; i_data = 32'd1; enable = 1'b1; RD0_WR1 = 1'b0;
    tick();
    lock_wr = 1'b0; enable = 1'b0;
    check("lock no access", {31'd0, o_valid}, 32'd0);
    wr(1, 2, 32'hDEAD_BEEF);
    check("locked wr err", {31'd0, o_err}, 32'd1);
    rd_check("locked rd", 1, 2, 32'h0BAD_F00D);
    clear_req = 1'b1; clear_guest = 1;
    tick();
    clear_req = 1'b0;
    check("locked clr done", {31'd0, clear_done}, 32'd1);
    check("locked clr err", {31'd0, o_err}, 32'd1);
    tick();
    rd_check("locked clr kept", 1, 2, 32'h0BAD_F00D);
    lock_wr = 1'b1; guest_line = 1; i_data = 32'd0;
    tick();
    lock_wr = 1'b0;
    wr(1, 2, 32'hDEAD_BEEF);
    check("unlocked wr err", {31'd0, o_err}, 32'd0);
    rd_check("unlocked rd", 1, 2, 32'hDEAD_BEEF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
